bus_src_driver: RTL and testbench
=================================

// Module: bus_src_driver
// PURPOSE
//  Source side of the shared 18-bit datapath bus. Queues move requests (source reg -> dest reg),
//  snapshots the selected source register, drives it onto the bus and pulses the matching
//  destination load strobe plus the global enable. Destination registers capture on the falling
//  clk edge; this block updates on the rising edge, so bus data is stable half a cycle before capture.
// PARAMETERS
//  DW     18  bus / register data width
//  NSRC   8   number of source registers on src_flat
//  SELW   3   width of the source and destination selects
//  NDST   6   number of destination load strobes (NDST <= 2**SELW)
//  QDEPTH 4   request FIFO depth (power of 2)
// PORTS
//  clk       in   1          single clock; all state updates on the rising edge
//  rst       in   1          synchronous, active-low reset
//  src_flat  in   NSRC*DW    source registers, src i = src_flat[i*DW +: DW]
//  req_valid in   1          move request present
//  req_ready out  1          request accepted this cycle when req_valid & req_ready
//  req_sel   in   SELW       source index
//  req_dst   in   SELW       destination index
//  stall     in   1          processor hold; freezes an in-progress drive
//  bus_out   out  DW         bus data
//  en        out  1          global load enable to destination registers
//  ld_en     out  NDST       one-hot destination select (swp-style strobe)
//  busy      out  1          FIFO non-empty or state != IDLE
//  err       out  1          sticky: invalid request seen
//  xfer_cnt  out  8          completed-transfer count, wraps 255 -> 0
// BEHAVIOUR
//  Reset (rst=0 at a rising edge): state=IDLE, FIFO empty, bus_out=0, en=0, ld_en=0,
//   err=0, xfer_cnt=0. req_ready=0 while rst=0. Reset mid-drive aborts: no strobe on the next cycle.
//  Push: req_ready = !full. A push and a pop in the same cycle while full still blocks the push.
//   A pushed entry is visible to the FSM the cycle after the push.
//  Validation at push: req_sel>=NSRC or req_dst>=NDST -> request consumed, not queued, err<=1.
//   err clears only on reset.
//  FSM states: IDLE, FETCH, DRIVE.
//   IDLE : FIFO non-empty -> FETCH.
//   FETCH: pop; bus_q<=src[sel]; dst_q<=dst -> DRIVE. The snapshot is taken here, not at push.
//   DRIVE: bus_out=bus_q; ld_en=onehot(dst_q); en=!stall.
//          stall=1 -> hold DRIVE with en=0 and ld_en held. Source changes do not alter bus_out.
//          stall=0 -> transfer completes this cycle; xfer_cnt+1; next state FETCH if FIFO
//          non-empty, otherwise IDLE.
//  Latency: push at edge N -> FETCH cycle N+1 -> en/ld_en high cycle N+2 (no stall).
//   Throughput is one transfer per 2 cycles back-to-back.
//  Outside DRIVE: en=0, ld_en=0, bus_out holds its last value (never tristated).
//  en and ld_en are registered. Their width is exactly one cycle per transfer when not stalled.
//  Requests complete in FIFO order. Capacity is QDEPTH queued plus 1 in flight.
// STRUCTURE
//  Package bus_pkg: DW, SELW, state enum {IDLE,FETCH,DRIVE}, request struct {sel,dst}.
//  Sub-module bus_req_fifo: synchronous FIFO of request structs with full/empty, QDEPTH deep,
//   same clk/rst. The FSM, snapshot register, strobe decode and counter live in the top level.
// TESTING
//  1 Reset: rst=0 for 2 cycles with req_valid=1 -> req_ready=0, bus_out=0, en=0, ld_en=0,
//    xfer_cnt=0, nothing queued after release.
//  2 Single move: src[2]=18'h2A5A3, push sel=2 dst=5 at edge 0 -> edge 2: bus_out=18'h2A5A3,
//    ld_en=6'b100000, en=1 for exactly 1 cycle; xfer_cnt=1; busy=0 at edge 3.
//  3 Fill: stall=1, push continuously -> exactly 5 accepted (1 DRIVE + 4 queued), then req_ready=0.
//    Release stall -> 5 strobes in push order, xfer_cnt=5.
//  4 Stall snapshot: during DRIVE with stall=1, change src[2] to 18'h00001 -> bus_out stays
//    18'h2A5A3 and en=0. Drop stall -> en=1 once with the old value.
//  5 Invalid: push dst=7 (NDST=6), then sel=9 with NSRC=8 widened sel -> err=1, no ld_en activity,
//    xfer_cnt unchanged. A subsequent valid move still completes.
//  6 Reset mid-operation: rst=0 in the DRIVE cycle with 2 queued -> next cycle en=0, ld_en=0,
//    FIFO empty, busy=0. After release, no stale transfer is driven.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the datapath source bus: FSM states and the queued move request.
package bus_pkg;
    localparam int DW   = 18;
    localparam int SELW = 3;

    typedef enum logic [1:0] {IDLE, FETCH, DRIVE} state_t;

    typedef struct packed {
        logic [SELW-1:0] sel;
        logic [SELW-1:0] dst;
    } bus_req_t;
endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module bus_req_fifo
    import bus_pkg::*;
#(
    parameter type T      = bus_req_t,
    parameter int  QDEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    T           mem [QDEPTH];
    logic [AW:0] wp, rp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];
endmodule

// File: rtl/bus_src_driver.sv
// Source side of the shared bus: queues moves, snapshots the source at FETCH and drives
// registered bus data plus one-hot load strobes while in DRIVE.
module bus_src_driver
    import bus_pkg::state_t, bus_pkg::IDLE, bus_pkg::FETCH, bus_pkg::DRIVE;
#(
    parameter int DW     = bus_pkg::DW,
    parameter int NSRC   = 8,
    parameter int SELW   = bus_pkg::SELW,
    parameter int NDST   = 6,
    parameter int QDEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSRC*DW-1:0] src_flat,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SELW-1:0]    req_sel,
    input  logic [SELW-1:0]    req_dst,
    input  logic               stall,
    output logic [DW-1:0]      bus_out,
    output logic               en,
    output logic [NDST-1:0]    ld_en,
    output logic               busy,
    output logic               err,
    output logic [7:0]         xfer_cnt
);
    typedef struct packed {
        logic [SELW-1:0] sel;
        logic [SELW-1:0] dst;
    } req_t;

    state_t          state, state_n;
    req_t            head, wreq;
    logic            full, empty, push, pop, req_ok;
    logic [DW-1:0]   src_sel;
    logic [NDST-1:0] dst_oh;

    assign req_ready = rst && !full;
    assign req_ok    = (int'(req_sel) < NSRC) && (int'(req_dst) < NDST);
    assign push      = req_valid && req_ready && req_ok;
    assign pop       = (state == FETCH);
    assign wreq      = '{sel: req_sel, dst: req_dst};
    assign busy      = !empty || (state != IDLE);

    bus_req_fifo #(.T(req_t), .QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wreq),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        src_sel = '0;
        for (int i = 0; i < NSRC; i++)
            if (int'(head.sel) == i) src_sel = src_flat[i*DW +: DW];
    end

    always_comb begin
        dst_oh = '0;
        for (int i = 0; i < NDST; i++)
            if (int'(head.dst) == i) dst_oh[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // en is high during DRIVE only once the transfer is unstalled; that cycle completes it
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!empty) state_n = FETCH;
            FETCH:   state_n = DRIVE;
            DRIVE:   if (en) state_n = empty ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_out  <= '0;
            en       <= 1'b0;
            ld_en    <= '0;
            err      <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (req_valid && req_ready && !req_ok) err <= 1'b1;
            case (state)
                FETCH: begin
                    bus_out <= src_sel;
                    ld_en   <= dst_oh;
                    en      <= !stall;
                end
                DRIVE: begin
                    if (en) begin
                        en       <= 1'b0;
                        ld_en    <= '0;
                        xfer_cnt <= xfer_cnt + 8'd1;
                    end else begin
                        en <= !stall;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    ld_en <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_src_driver.sv
// Bench for bus_src_driver: queue-based reference model checked every cycle, plus directed cases.
module tb_bus_src_driver;
    localparam int DW = 18, NSRC = 8, SELW = 4, NDST = 6, QD = 4;

    logic               clk = 0;
    logic               rst;
    logic [NSRC*DW-1:0] src_flat;
    logic               req_valid, req_ready, stall, en, busy, err;
    logic [SELW-1:0]    req_sel, req_dst;
    logic [DW-1:0]      bus_out;
    logic [NDST-1:0]    ld_en;
    logic [7:0]         xfer_cnt;

    int checks = 0, failures = 0;

    bus_src_driver #(.DW(DW), .NSRC(NSRC), .SELW(SELW), .NDST(NDST), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .src_flat(src_flat), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_dst(req_dst), .stall(stall), .bus_out(bus_out), .en(en),
        .ld_en(ld_en), .busy(busy), .err(err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending moves in a queue; phase 0 idle, 1 fetching, 2 driving
    typedef struct {int sel; int dst;} mreq_t;
    mreq_t           mq[$];
    int              ph;
    logic [DW-1:0]   m_bus;
    logic            m_en, m_err, m_on = 0;
    logic [NDST-1:0] m_ld;
    logic [7:0]      m_cnt;

    always @(posedge clk) begin
        bit full_pre, empty_pre;
        mreq_t r;
        if (!rst) begin
            mq.delete(); ph = 0; m_bus = '0; m_en = 0; m_ld = '0; m_cnt = '0; m_err = 0; m_on = 1;
        end else if (m_on) begin
            full_pre  = (mq.size() >= QD);
            empty_pre = (mq.size() == 0);
            if (ph == 0) begin
                if (!empty_pre) ph = 1;
            end else if (ph == 1) begin
                r = mq.pop_front();
                m_bus = src_flat[r.sel*DW +: DW];
                m_ld  = NDST'(1 << r.dst);
                m_en  = !stall;
                ph = 2;
            end else if (m_en) begin
                m_cnt++;
                m_en = 0; m_ld = '0;
                ph = empty_pre ? 0 : 1;
            end else begin
                m_en = !stall;
            end
            if (req_valid && !full_pre) begin
                if (req_sel < NSRC && req_dst < NDST) mq.push_back('{int'(req_sel), int'(req_dst)});
                else m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_bus_out",   32'(bus_out),   32'(m_bus));
            chk("m_en",        32'(en),        32'(m_en));
            chk("m_ld_en",     32'(ld_en),     32'(m_ld));
            chk("m_xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
            chk("m_err",       32'(err),       32'(m_err));
            chk("m_busy",      32'(busy),      32'((mq.size() != 0) || (ph != 0)));
            chk("m_req_ready", 32'(req_ready), 32'(rst && (mq.size() < QD)));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setsrc(input int i, input logic [DW-1:0] v);
        src_flat[i*DW +: DW] = v;
    endtask

    initial begin
        int acc, pulses, base;
        bit found;
        logic [DW-1:0] v;

        for (int i = 0; i < NSRC; i++) setsrc(i, DW'($urandom));
        setsrc(2, 18'h2A5A3);
        rst = 0; req_valid = 1; req_sel = 0; req_dst = 0; stall = 0;

        // 1 reset with req_valid held high
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_bus", 32'(bus_out), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_ld", 32'(ld_en), 0);
        chk("rst_cnt", 32'(xfer_cnt), 0);
        req_valid = 0; rst = 1;
        tick(); tick();
        chk("rst_nothing_queued", 32'(busy), 0);

        // 2 single move
        req_valid = 1; req_sel = 2; req_dst = 5;
        tick(); req_valid = 0;
        tick();
        tick();
        chk("single_bus", 32'(bus_out), 32'h2A5A3);
        chk("single_ld", 32'(ld_en), 32'b100000);
        chk("single_en", 32'(en), 1);
        tick();
        chk("single_en_off", 32'(en), 0);
        chk("single_cnt", 32'(xfer_cnt), 1);
        chk("single_busy", 32'(busy), 0);

        // 3 fill under stall; first request also drives the stall-snapshot case
        stall = 1; acc = 0; req_valid = 1;
        for (int k = 0; k < 12; k++) begin
            req_sel = (k == 0) ? 4'd2 : SELW'($urandom_range(0, NSRC-1));
            req_dst = (k == 0) ? 4'd1 : SELW'($urandom_range(0, NDST-1));
            if (req_ready) acc++;
            tick();
        end
        chk("fill_accepted", 32'(acc), 5);
        chk("fill_ready_low", 32'(req_ready), 0);
        req_valid = 0;

        // 4 source changes while stalled in DRIVE must not reach the bus
        setsrc(2, 18'h00001);
        tick();
        chk("stall_bus_held", 32'(bus_out), 32'h2A5A3);
        chk("stall_en", 32'(en), 0);
        chk("stall_ld", 32'(ld_en), 32'b000010);
        stall = 0; pulses = 0; base = int'(xfer_cnt);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (en) begin
                if (pulses == 0) chk("stall_first_bus", 32'(bus_out), 32'h2A5A3);
                pulses++;
            end
        end
        chk("fill_pulses", 32'(pulses), 5);
        chk("fill_cnt", 32'(xfer_cnt), 32'((base + 5) & 255));

        // 5 invalid requests
        chk("err_clear", 32'(err), 0);
        base = int'(xfer_cnt);
        req_valid = 1; req_sel = 0; req_dst = 7;
        tick();
        req_sel = 9; req_dst = 0;
        tick();
        req_valid = 0; pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (en || ld_en != 0) pulses++;
        end
        chk("inv_err", 32'(err), 1);
        chk("inv_no_strobe", 32'(pulses), 0);
        chk("inv_cnt", 32'(xfer_cnt), 32'(base));
        v = DW'($urandom);
        setsrc(3, v);
        req_valid = 1; req_sel = 3; req_dst = 0;
        tick(); req_valid = 0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (en) begin
                found = 1;
                chk("inv_then_bus", 32'(bus_out), 32'(v));
                chk("inv_then_ld", 32'(ld_en), 1);
            end
        end
        chk("inv_then_done", 32'(found), 1);

        // 6 reset during DRIVE with two queued
        stall = 1; req_valid = 1; req_sel = 1; req_dst = 4;
        tick(); tick(); tick();
        req_valid = 0;
        chk("mid_in_drive_ld", 32'(ld_en), 32'b010000);
        rst = 0;
        tick();
        chk("mid_en", 32'(en), 0);
        chk("mid_ld", 32'(ld_en), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_err", 32'(err), 0);
        rst = 1; stall = 0; pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (en) pulses++;
        end
        chk("mid_no_stale", 32'(pulses), 0);
        chk("mid_cnt", 32'(xfer_cnt), 0);

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            req_valid = ($urandom_range(0, 99) < 60);
            req_sel   = ($urandom_range(0, 99) < 8) ? SELW'($urandom_range(8, 15)) : SELW'($urandom_range(0, NSRC-1));
            req_dst   = ($urandom_range(0, 99) < 8) ? SELW'($urandom_range(6, 7)) : SELW'($urandom_range(0, NDST-1));
            stall     = ($urandom_range(0, 99) < 30);
            rst       = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) setsrc($urandom_range(0, NSRC-1), DW'($urandom));
            tick();
        end
        rst = 1; req_valid = 0; stall = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
